mix_tree_sequencer: RTL and testbench
=====================================

MIX_TREE_SEQUENCER -- requirements
Module: mix_tree_sequencer

Interface
REQ-001 The block SHALL have parameter PULSE_CYCLES, default 8: cycles each inlet valve is held open (>=1).
REQ-002 The block SHALL have parameter MIX_CYCLES, default 64: settle cycles with all valves closed after loading (>=1).
REQ-003 The block SHALL have parameter FLUSH_CYCLES, default 16: cycles the outlet valves are held open (>=1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit: run request, accepted when start=1 and ready=1 at a rising edge.
REQ-007 The block SHALL have port tree_mask, input, 4 bits: trees to run, bit t = tree t; sampled only on accept.
REQ-008 The block SHALL have port abort, input, 1 bit: terminate the current run.
REQ-009 The block SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-010 The block SHALL have port inlet_valve, output, 16 bits: one-hot-or-zero inlet drive; bit 4*t+l = leaf l of tree t, matching the mixer-tree input_0..input_15 order.
REQ-011 The block SHALL have port outlet_valve, output, 4 bits: bit t drives the valve on tree output out_t.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse at normal run completion.
REQ-013 The block SHALL have port aborted, output, 1 bit: one-cycle pulse when a run is aborted.

Function
REQ-014 The block SHALL implement FSM states IDLE, LOAD, MIX, FLUSH and DONE.
REQ-015 On accept at edge k, the block SHALL latch tree_mask and leave IDLE; ready SHALL be 0 from cycle k+1.
REQ-016 In LOAD, the block SHALL open the inlets of the enabled trees in ascending index order, each for exactly PULSE_CYCLES cycles, back-to-back with no gap; the first inlet opens in cycle k+1.
REQ-017 Disabled trees SHALL be skipped with zero cycles spent, and at most one inlet_valve bit SHALL be high in any cycle.
REQ-018 In MIX, all valves SHALL be closed for exactly MIX_CYCLES cycles.
REQ-019 In FLUSH, outlet_valve SHALL equal the latched mask for exactly FLUSH_CYCLES cycles, and inlet_valve SHALL be 0.
REQ-020 In DONE, done SHALL be 1 for one cycle, then the FSM SHALL return to IDLE; done for n enabled trees occurs in cycle k+1+4*n*PULSE_CYCLES+MIX_CYCLES+FLUSH_CYCLES.
REQ-021 If the latched mask is 0, the block SHALL skip LOAD, MIX and FLUSH, assert done in cycle k+1, and open no valve.
REQ-022 start while not ready SHALL be ignored, and tree_mask changes during a run SHALL have no effect.
REQ-023 abort=1 sampled outside IDLE SHALL, from the next cycle, close all valves, assert aborted for one cycle and place the FSM in IDLE (ready=1 in that same cycle).
REQ-024 abort in IDLE SHALL be ignored; if start and abort are both 1 in IDLE, abort SHALL win: no accept and no aborted pulse.
REQ-025 An abort sampled in the DONE cycle SHALL be ignored: done fires and aborted does not.
REQ-026 Every output SHALL be registered, and the block SHALL contain no combinational path from an input to an output.
REQ-027 The cycle counter SHALL be $clog2 of the largest of PULSE_CYCLES, MIX_CYCLES and FLUSH_CYCLES bits wide, SHALL count down to 1, and SHALL reload on each phase or valve change.

Reset
REQ-028 While rst_n=0, the block SHALL asynchronously force state=IDLE, inlet_valve=0, outlet_valve=0, done=0, aborted=0, ready=1, latched mask=0 and counter=0.
REQ-029 Reset asserted mid-run SHALL close all valves immediately, and the block SHALL emit no done or aborted pulse.
REQ-030 After rst_n rises, the first accept SHALL be possible on the first rising edge.

Structure
REQ-031 Package mix_tree_pkg SHALL hold the state enum and the constants N_TREES=4, LEAVES_PER_TREE=4 and N_INLETS=16.
REQ-032 The phase timer SHALL be the single sub-module mfda_phase_timer (load value, enable, expire flag), instanced once.
REQ-033 Valve index generation (tree, leaf) SHALL live in the top module.

Verification
REQ-034 With defaults and tree_mask=0001, start at edge k SHALL drive inlet 0,1,2,3 each for 8 cycles over k+1..k+32, then all valves closed for k+33..k+96, then outlet=0001 for k+97..k+112, then done at k+113.
REQ-035 With tree_mask=1010, inlets 4..7 then 12..15 SHALL open (8 cycles each), outlet=1010 SHALL be driven in flush, and done SHALL occur at k+145.
REQ-036 With tree_mask=0000, done SHALL occur at k+1, with no valve activity and ready=1 at k+2.
REQ-037 Abort at k+20 (mid-LOAD, mask=1111) SHALL give all valves 0 and aborted=1 at k+21 and ready=1, with no done afterwards.
REQ-038 A start with mask=1111 at k+50 of a running mask=0001 job SHALL be ignored, and outlet SHALL remain 0001 in flush.
REQ-039 rst_n low for 2 cycles mid-MIX SHALL hold all outputs at their reset values, produce no pulses, and allow a fresh run to complete normally afterwards.

Source files
------------

// File: rtl/mix_tree_pkg.sv
// mix_tree_pkg: shared types and constants for the mixer-tree valve sequencer.
//   state_t    : sequencer phases
//   first_tree : lowest enabled tree index at or above a start index (N_TREES if none)
package mix_tree_pkg;
    localparam int N_TREES         = 4;
    localparam int LEAVES_PER_TREE = 4;
    localparam int N_INLETS        = N_TREES * LEAVES_PER_TREE;
    localparam int TREE_W          = $clog2(N_TREES);
    localparam int LEAF_W          = $clog2(LEAVES_PER_TREE);

    typedef enum logic [2:0] {IDLE, LOAD, MIX, FLUSH, DONE} state_t;

    function automatic int first_tree(input logic [N_TREES-1:0] m, input int from);
        first_tree = N_TREES;
        for (int i = N_TREES - 1; i >= 0; i--)
            if (i >= from && m[i]) first_tree = i;
    endfunction
endpackage

// File: rtl/mfda_phase_timer.sv
// mfda_phase_timer: down-counter that times one sequencer phase or valve pulse.
//   clk, rst_n : clock, async active-low reset (counter cleared to 0)
//   load       : load load_val this cycle (has priority over en)
//   en         : decrement by one
//   load_val   : cycles to count; 0 stands for 2**W so a full power-of-two span fits in W bits
//   expired    : counter is at 1, i.e. this is the last cycle of the span
module mfda_phase_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         expired
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en) cnt <= cnt - W'(1);

    assign expired = cnt == W'(1);
endmodule

// File: rtl/mix_tree_sequencer.sv
// mix_tree_sequencer: loads, mixes and flushes up to four mixer trees in sequence.
//   clk, rst_n   : clock, async active-low reset
//   start        : run request, accepted when ready
//   tree_mask    : trees to run (bit t = tree t), sampled on accept
//   abort        : terminate the current run
//   ready        : high only in IDLE
//   inlet_valve  : one-hot-or-zero inlet drive, bit 4*t+l = leaf l of tree t
//   outlet_valve : per-tree outlet drive during flush
//   done         : one-cycle pulse at normal completion
//   aborted      : one-cycle pulse when a run is aborted
// All outputs are registers loaded from the next-state values.
module mix_tree_sequencer
    import mix_tree_pkg::*;
#(
    parameter int PULSE_CYCLES = 8,
    parameter int MIX_CYCLES   = 64,
    parameter int FLUSH_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [N_TREES-1:0]  tree_mask,
    input  logic                abort,
    output logic                ready,
    output logic [N_INLETS-1:0] inlet_valve,
    output logic [N_TREES-1:0]  outlet_valve,
    output logic                done,
    output logic                aborted
);
    localparam int MAXC = PULSE_CYCLES > MIX_CYCLES ?
                          (PULSE_CYCLES > FLUSH_CYCLES ? PULSE_CYCLES : FLUSH_CYCLES) :
                          (MIX_CYCLES > FLUSH_CYCLES ? MIX_CYCLES : FLUSH_CYCLES);
    localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
    // A span equal to 2**CW truncates to 0, which the timer counts as a full wrap.
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES);
    localparam logic [CW-1:0] MIX_LD   = CW'(MIX_CYCLES);
    localparam logic [CW-1:0] FLUSH_LD = CW'(FLUSH_CYCLES);

    state_t              state, state_n;
    logic [N_TREES-1:0]  mask, mask_n;
    logic [TREE_W-1:0]   tree, tree_n;
    logic [LEAF_W-1:0]   leaf, leaf_n;
    logic [N_INLETS-1:0] inlet_n;
    logic [N_TREES-1:0]  outlet_n;
    logic                aborted_n;
    logic                t_load, expired;
    logic [CW-1:0]       t_val;
    int                  nxt_run, nxt_load;

    mfda_phase_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .en       (state != IDLE),
        .load_val (t_val),
        .expired  (expired)
    );

    always_comb begin
        state_n   = state;
        mask_n    = mask;
        tree_n    = tree;
        leaf_n    = leaf;
        aborted_n = 1'b0;
        t_load    = 1'b0;
        t_val     = PULSE_LD;
        nxt_run   = first_tree(tree_mask, 0);
        nxt_load  = first_tree(mask, int'(tree) + 1);
        case (state)
            IDLE:
                if (start && !abort) begin
                    mask_n  = tree_mask;
                    state_n = tree_mask == '0 ? DONE : LOAD;
                    tree_n  = TREE_W'(nxt_run);
                    leaf_n  = '0;
                    t_load  = 1'b1;
                end
            LOAD:
                if (expired) begin
                    t_load = 1'b1;
                    if (leaf != LEAF_W'(LEAVES_PER_TREE - 1)) leaf_n = leaf + LEAF_W'(1);
                    else if (nxt_load < N_TREES) begin
                        tree_n = TREE_W'(nxt_load);
                        leaf_n = '0;
                    end else begin
                        state_n = MIX;
                        t_val   = MIX_LD;
                    end
                end
            MIX:
                if (expired) begin
                    state_n = FLUSH;
                    t_load  = 1'b1;
                    t_val   = FLUSH_LD;
                end
            FLUSH:   if (expired) state_n = DONE;
            default: state_n = IDLE;
        endcase
        // Abort is honoured only while valves may be moving; DONE always completes.
        if (abort && state inside {LOAD, MIX, FLUSH}) begin
            state_n   = IDLE;
            aborted_n = 1'b1;
            t_load    = 1'b0;
        end
        inlet_n = '0;
        if (state_n == LOAD) inlet_n[{tree_n, leaf_n}] = 1'b1;
        outlet_n = state_n == FLUSH ? mask_n : '0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state        <= IDLE;
            mask         <= '0;
            tree         <= '0;
            leaf         <= '0;
            inlet_valve  <= '0;
            outlet_valve <= '0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            ready        <= 1'b1;
        end else begin
            state        <= state_n;
            mask         <= mask_n;
            tree         <= tree_n;
            leaf         <= leaf_n;
            inlet_valve  <= inlet_n;
            outlet_valve <= outlet_n;
            done         <= state_n == DONE;
            aborted      <= aborted_n;
            ready        <= state_n == IDLE;
        end
endmodule

// File: tb/tb_mix_tree_sequencer.sv
// tb_mix_tree_sequencer: scoreboard bench; expected per-cycle outputs are queued from the run timeline.
module tb_mix_tree_sequencer;
    localparam int P = 8;
    localparam int M = 64;
    localparam int F = 16;
    // Output vector = {inlet_valve, outlet_valve, ready, done, aborted}
    localparam logic [22:0] IDLEV  = 23'h4;
    localparam logic [22:0] DONEV  = 23'h2;
    localparam logic [22:0] ABORTV = 23'h5;

    typedef struct {
        string       tag;
        logic [22:0] v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, start, abort;
    logic [3:0]  tree_mask;
    logic        ready, done, aborted;
    logic [15:0] inlet_valve;
    logic [3:0]  outlet_valve;
    logic [22:0] obs;
    exp_t        q[$];
    int          compared = 0;
    int          mismatched = 0;

    mix_tree_sequencer #(.PULSE_CYCLES(P), .MIX_CYCLES(M), .FLUSH_CYCLES(F)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .tree_mask    (tree_mask),
        .abort        (abort),
        .ready        (ready),
        .inlet_valve  (inlet_valve),
        .outlet_valve (outlet_valve),
        .done         (done),
        .aborted      (aborted)
    );

    always #5 clk = ~clk;
    assign obs = {inlet_valve, outlet_valve, ready, done, aborted};

    task automatic push(input string tag, input logic [22:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        q.push_back(e);
    endtask

    // Expected outputs for cycles k+1 .. k+lim of a run accepted at edge k.
    task automatic push_run(input string name, input logic [3:0] m, input int lim);
        int          tl[$];
        int          l;
        logic [15:0] v;
        for (int t = 0; t < 4; t++) if (m[t]) tl.push_back(t);
        l = 4 * tl.size() * P;
        if (tl.size() == 0) begin
            if (lim >= 1) push($sformatf("%s_done", name), DONEV);
            if (lim >= 2) push($sformatf("%s_idle", name), IDLEV);
        end else
            for (int j = 1; j <= l + M + F + 2 && j <= lim; j++) begin
                if (j <= l) begin
                    v = 16'd1 << (4 * tl[(j - 1) / (4 * P)] + ((j - 1) / P) % 4);
                    push($sformatf("%s_load_c%0d", name, j), {v, 4'b0, 3'b000});
                end else if (j <= l + M) push($sformatf("%s_mix_c%0d", name, j), 23'h0);
                else if (j <= l + M + F) push($sformatf("%s_flush_c%0d", name, j), {16'b0, m, 3'b000});
                else if (j == l + M + F + 1) push($sformatf("%s_done_c%0d", name, j), DONEV);
                else push($sformatf("%s_idle_c%0d", name, j), IDLEV);
            end
    endtask

    task automatic ticks(input int n);
        exp_t e;
        repeat (n) begin
            @(negedge clk);
            if (q.size() == 0) begin
                mismatched++;
                $display("FAIL scoreboard_underflow: observed %h required an expectation", obs);
            end else begin
                e = q.pop_front();
                compared++;
                assert (obs === e.v) else begin
                    mismatched++;
                    $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
                end
            end
        end
    endtask

    task automatic drain();
        ticks(q.size());
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; tree_mask = 4'b0;
        push("reset0", IDLEV); push("reset1", IDLEV);
        drain();
        rst_n = 1'b1;
        // Single tree 0; mask change mid-run must not matter
        start = 1'b1; tree_mask = 4'b0001;
        push_run("m0001", 4'b0001, 1000);
        ticks(1);
        start = 1'b0; tree_mask = 4'b1111;
        drain();
        // Trees 1 and 3
        start = 1'b1; tree_mask = 4'b1010;
        push_run("m1010", 4'b1010, 1000);
        ticks(1);
        start = 1'b0;
        drain();
        // Empty mask
        start = 1'b1; tree_mask = 4'b0000;
        push_run("m0000", 4'b0000, 1000);
        ticks(1);
        start = 1'b0;
        drain();
        // Abort mid-LOAD at k+20
        start = 1'b1; tree_mask = 4'b1111;
        push_run("abrt", 4'b1111, 20);
        push("abrt_pulse", ABORTV);
        push("abrt_idle0", IDLEV); push("abrt_idle1", IDLEV); push("abrt_idle2", IDLEV);
        ticks(1);
        start = 1'b0;
        ticks(19);
        abort = 1'b1;
        ticks(1);
        abort = 1'b0;
        drain();
        // Start while busy at k+50 is ignored
        start = 1'b1; tree_mask = 4'b0001;
        push_run("busy", 4'b0001, 1000);
        ticks(1);
        start = 1'b0;
        ticks(49);
        start = 1'b1; tree_mask = 4'b1111;
        ticks(1);
        start = 1'b0;
        drain();
        // Start and abort together in IDLE: abort wins, no pulse
        start = 1'b1; abort = 1'b1; tree_mask = 4'b0001;
        push("sa_idle0", IDLEV); push("sa_idle1", IDLEV);
        ticks(1);
        start = 1'b0; abort = 1'b0;
        drain();
        // Abort sampled in DONE is ignored
        start = 1'b1; tree_mask = 4'b0000;
        push_run("dabrt", 4'b0000, 1000);
        push("dabrt_idle", IDLEV);
        ticks(1);
        start = 1'b0; abort = 1'b1;
        ticks(1);
        abort = 1'b0;
        drain();
        // Reset mid-MIX, then a fresh run right after release
        start = 1'b1; tree_mask = 4'b0001;
        push_run("rst", 4'b0001, 40);
        ticks(1);
        start = 1'b0;
        ticks(39);
        rst_n = 1'b0;
        #1;
        compared++;
        assert (obs === IDLEV) else begin
            mismatched++;
            $error("FAIL rst_async: observed %h expected %h", obs, IDLEV);
        end
        push("rst_hold0", IDLEV); push("rst_hold1", IDLEV);
        ticks(2);
        rst_n = 1'b1; start = 1'b1; tree_mask = 4'b0001;
        push_run("post_rst", 4'b0001, 1000);
        ticks(1);
        start = 1'b0;
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
